// File: rtl/euler_join_unit_if.sv
// euler_join_unit_if: channel-side handshake/data and state-RAM write port of the join unit.
// Latency: none, wiring only.
// Backpressure: ch_ready is the only return path; the RAM port has no stall.
interface euler_join_unit_if #(
  parameter int NUM_CH    = 2,
  parameter int DATA_SIZE = 16,
  parameter int ADD_SIZE  = 16
);
  logic [NUM_CH-1:0]           ch_valid;
  logic [NUM_CH*DATA_SIZE-1:0] ch_data;
  logic [NUM_CH-1:0]           ch_ready;
  logic [DATA_SIZE-1:0]        h_step;
  logic                        mem_we;
  logic [ADD_SIZE-1:0]         mem_addr;
  logic [DATA_SIZE-1:0]        mem_wdata;

  // upstream pipes / controller side
  modport master (
    output ch_valid, ch_data, h_step,
    input  ch_ready, mem_we, mem_addr, mem_wdata
  );

  // join unit side
  modport slave (
    input  ch_valid, ch_data, h_step,
    output ch_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/euler_join_unit.sv
// euler_join_unit: sums NUM_CH derivative terms, scales by h_step (shift-add), writes to state RAM.
// Latency: accept at edge T -> mem_we during cycle T+DATA_SIZE+1; one result per DATA_SIZE+2 cycles.
// Backpressure: all-or-nothing ch_ready, only in IDLE. Optional macro JOIN_SATURATE_EN clamps overflow.
module euler_join_unit #(
  parameter int          NUM_CH    = 2,
  parameter int          DATA_SIZE = 16,
  parameter int          FRAC_BITS = 8,
  parameter int          ADD_SIZE  = 16,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  euler_join_unit_if.slave      bus,
  output logic                  busy,
  output logic                  finished,
  output logic                  overflow_flag
);

  localparam int S     = DATA_SIZE + $clog2(NUM_CH);  // sum width, cannot overflow
  localparam int P     = S + DATA_SIZE;                // product width
  localparam int CNT_W = $clog2(DATA_SIZE);
  localparam logic [ADD_SIZE-1:0] BASE = ADD_SIZE'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, MUL, WRITE} state_t;

  state_t state, state_nxt;

  logic                  accept;
  logic                  last;
  logic signed [S-1:0]   sum_c;
  logic [S-1:0]          sum_u;
  logic [S-1:0]          sum_mag;
  logic [DATA_SIZE-1:0]  h_mag;
  logic                  neg_c;

  logic [P-1:0]          mcand;
  logic [DATA_SIZE-1:0]  mplr;
  logic [P-1:0]          acc;
  logic                  neg;
  logic [CNT_W-1:0]      cnt;
  logic [P-1:0]          acc_nxt;
  logic signed [P-1:0]   prod_s;
  logic signed [P-1:0]   res_full;
  logic                  fits;
  logic [DATA_SIZE-1:0]  wdata_c;

  logic [ADD_SIZE-1:0]   addr_cnt;
  logic [ADD_SIZE-1:0]   addr_q;
  logic [DATA_SIZE-1:0]  wdata_q;

  assign accept = (state == IDLE) && (&bus.ch_valid) && !clear;
  assign last   = (cnt == CNT_W'(DATA_SIZE - 1));

  // sign-extended sum of all channel terms
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum_c = sum_c + S'($signed(bus.ch_data[i*DATA_SIZE +: DATA_SIZE]));
    end
  end

  // operand magnitudes; the sign is reapplied after the last partial product
  assign sum_u   = sum_c;
  assign sum_mag = sum_c[S-1] ? (~sum_u + S'(1)) : sum_u;
  assign h_mag   = bus.h_step[DATA_SIZE-1] ? (~bus.h_step + DATA_SIZE'(1)) : bus.h_step;
  assign neg_c   = sum_c[S-1] ^ bus.h_step[DATA_SIZE-1];

  assign acc_nxt  = acc + (mplr[0] ? mcand : '0);
  assign prod_s   = neg ? -$signed(acc_nxt) : $signed(acc_nxt);
  assign res_full = prod_s >>> FRAC_BITS;
  assign fits     = (&res_full[P-1:DATA_SIZE-1]) || !(|res_full[P-1:DATA_SIZE-1]);

`ifdef JOIN_SATURATE_EN
  assign wdata_c = fits ? res_full[DATA_SIZE-1:0]
                 : (res_full[P-1] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                  : {1'b0, {(DATA_SIZE-1){1'b1}}});
`else
  assign wdata_c = res_full[DATA_SIZE-1:0];
`endif

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // next state and handshake/write strobes
  always_comb begin
    state_nxt    = state;
    bus.ch_ready = '0;
    bus.mem_we   = 1'b0;
    finished     = 1'b0;
    busy         = (state != IDLE);
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          bus.ch_ready = {NUM_CH{accept}};
          if (accept) state_nxt = MUL;
        end
        MUL: begin
          if (last) state_nxt = WRITE;
        end
        WRITE: begin
          bus.mem_we = 1'b1;
          finished   = 1'b1;
          state_nxt  = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // multiplier datapath, result/address registers, sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand <= '0; mplr <= '0; acc <= '0; neg <= 1'b0; cnt <= '0;
      addr_cnt <= BASE; addr_q <= BASE; wdata_q <= '0; overflow_flag <= 1'b0;
    end else if (clear) begin
      mcand <= '0; mplr <= '0; acc <= '0; neg <= 1'b0; cnt <= '0;
      addr_cnt <= BASE; addr_q <= BASE; wdata_q <= '0; overflow_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand <= P'(sum_mag);
            mplr  <= h_mag;
            acc   <= '0;
            neg   <= neg_c;
            cnt   <= '0;
          end
        end
        MUL: begin
          acc   <= acc_nxt;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + CNT_W'(1);
          if (last) begin
            wdata_q <= wdata_c;
            addr_q  <= addr_cnt;
            if (!fits) overflow_flag <= 1'b1;
          end
        end
        WRITE: addr_cnt <= addr_cnt + ADD_SIZE'(1);
        default: ;
      endcase
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_euler_join_unit.sv
// tb_euler_join_unit: directed vectors, expectations queued at accept and checked by write monitors.
// Latency: expected write cycle is accept cycle + 17 for DATA_SIZE=16.
// Backpressure: ready is checked low whenever the unit is busy.
module tb_euler_join_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clear, rst2, clear2;
  logic busy1, fin1, ovf1, busy2, fin2, ovf2;

  euler_join_unit_if #(.NUM_CH(2), .DATA_SIZE(16), .ADD_SIZE(16)) bus1 ();
  euler_join_unit_if #(.NUM_CH(2), .DATA_SIZE(16), .ADD_SIZE(2))  bus2 ();

  euler_join_unit #(.NUM_CH(2), .DATA_SIZE(16), .FRAC_BITS(8), .ADD_SIZE(16), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus1),
    .busy(busy1), .finished(fin1), .overflow_flag(ovf1)
  );

  euler_join_unit #(.NUM_CH(2), .DATA_SIZE(16), .FRAC_BITS(8), .ADD_SIZE(2), .BASE_ADDR(0)) u_dut2 (
    .clk(clk), .rst(rst2), .clear(clear2), .bus(bus2),
    .busy(busy2), .finished(fin2), .overflow_flag(ovf2)
  );

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   exp_addr = 0;
  int   acc_n, last_c, n2;
  logic done2 = 1'b0;

  localparam int LAT = 17;
`ifdef JOIN_SATURATE_EN
  localparam logic [15:0] OVF_POS = 16'h7FFF;
  localparam logic [15:0] OVF_NEG = 16'h8000;
`else
  localparam logic [15:0] OVF_POS = 16'hF800;
  localparam logic [15:0] OVF_NEG = 16'h0800;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // drive one transaction on bus1, queue its expected write, then scramble inputs
  task automatic issue(input logic [15:0] d0, input logic [15:0] d1,
                       input logic [15:0] h, input logic [15:0] wexp);
    exp_t e;
    @(negedge clk);
    bus1.ch_data  = {d1, d0};
    bus1.h_step   = h;
    bus1.ch_valid = 2'b11;
    #1;
    chk("accept_ready", bus1.ch_ready, 2'b11);
    e.addr = exp_addr % 65536;
    e.data = int'(wexp);
    e.cyc  = cyc + LAT;
    q1.push_back(e);
    exp_addr++;
    @(negedge clk);
    bus1.ch_valid = 2'b00;
    bus1.ch_data  = $urandom;
    bus1.h_step   = 16'($urandom);
  endtask

  // write monitor for the main instance
  always @(negedge clk) begin : mon1
    exp_t e;
    if (busy1) chk("ready_while_busy", bus1.ch_ready, 2'b00);
    if (bus1.mem_we || fin1) begin
      chk("finished_with_we", fin1, bus1.mem_we);
      if (q1.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, want no write", bus1.mem_addr, bus1.mem_wdata);
      end else begin
        e = q1.pop_front();
        chk("wr_addr", bus1.mem_addr, e.addr);
        chk("wr_data", bus1.mem_wdata, e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
  end

  // write monitor for the 2-bit address instance
  always @(negedge clk) begin : mon2
    exp_t e;
    if (bus2.mem_we) begin
      if (q2.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL wrap_unexpected_write: got addr 0x%0h, want no write", bus2.mem_addr);
      end else begin
        e = q2.pop_front();
        chk("wrap_addr", bus2.mem_addr, e.addr);
        chk("wrap_data", bus2.mem_wdata, e.data);
      end
    end
  end

  // address wrap stimulus: five results through a 2-bit address counter
  initial begin : stim2
    exp_t e;
    rst2 = 1'b0; clear2 = 1'b0; n2 = 0;
    bus2.ch_valid = 2'b00;
    bus2.ch_data  = {16'h0200, 16'h0100};
    bus2.h_step   = 16'h0080;
    repeat (2) @(negedge clk);
    rst2 = 1'b1;
    @(negedge clk);
    bus2.ch_valid = 2'b11;
    for (int i = 0; i < 150 && n2 < 5; i++) begin
      #1;
      if (bus2.ch_ready == 2'b11) begin
        e.addr = n2 % 4;
        e.data = 'h0180;
        e.cyc  = cyc + LAT;
        q2.push_back(e);
        n2++;
      end
      @(negedge clk);
    end
    bus2.ch_valid = 2'b00;
    chk("wrap_accepts", n2, 5);
    repeat (25) @(negedge clk);
    done2 = 1'b1;
  end

  initial begin : stim1
    exp_t e;
    rst = 1'b0; clear = 1'b0;
    bus1.ch_valid = 2'b00; bus1.ch_data = '0; bus1.h_step = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_addr", bus1.mem_addr, 0);
    chk("rst_we", bus1.mem_we, 0);
    chk("rst_finished", fin1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_ovf", ovf1, 0);
    chk("rst_wdata", bus1.mem_wdata, 0);
    chk("rst_ready", bus1.ch_ready, 0);
    @(negedge clk);
    rst = 1'b1;

    // 1.0 + 2.0 scaled by 0.5
    issue(16'h0100, 16'h0200, 16'h0080, 16'h0180);
    repeat (20) @(negedge clk);
    #1;
    chk("hold_addr", bus1.mem_addr, 0);
    chk("hold_wdata", bus1.mem_wdata, 16'h0180);
    chk("idle_busy", busy1, 0);

    // partial valid must not be consumed
    @(negedge clk);
    bus1.ch_valid = 2'b01;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (i % 10 == 0) begin
        chk("partial_ready", bus1.ch_ready, 0);
        chk("partial_busy", busy1, 0);
      end
    end
    // 3.0 - 2.0 scaled by -1.0
    issue(16'h0300, 16'hFE00, 16'hFF00, 16'hFF00);
    repeat (20) @(negedge clk);
    // -1/256 * 0.5 truncates toward -inf
    issue(16'hFFFF, 16'h0000, 16'h0080, 16'hFFFF);
    repeat (20) @(negedge clk);
    // +1/256 * 0.5 truncates to zero
    issue(16'h0001, 16'h0000, 16'h0080, 16'h0000);
    repeat (20) @(negedge clk);

    // clear, then three back-to-back results with valids held
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0; exp_addr = 0;
    #1;
    chk("clear_addr", bus1.mem_addr, 0);
    bus1.ch_data = {16'h0200, 16'h0100}; bus1.h_step = 16'h0080; bus1.ch_valid = 2'b11;
    acc_n = 0; last_c = 0;
    for (int i = 0; i < 80 && acc_n < 3; i++) begin
      #1;
      if (bus1.ch_ready == 2'b11) begin
        if (acc_n > 0) chk("b2b_spacing", cyc - last_c, 18);
        last_c = cyc;
        e.addr = exp_addr; e.data = 'h0180; e.cyc = cyc + LAT;
        q1.push_back(e);
        exp_addr++;
        acc_n++;
      end
      @(negedge clk);
    end
    bus1.ch_valid = 2'b00;
    chk("b2b_accepts", acc_n, 3);
    repeat (20) @(negedge clk);

    // overflow, sticky flag, negative saturation
    issue(16'h7F00, 16'h7F00, 16'h0400, OVF_POS);
    repeat (20) @(negedge clk);
    chk("ovf_set", ovf1, 1);
    issue(16'h0100, 16'h0200, 16'h0080, 16'h0180);
    repeat (20) @(negedge clk);
    chk("ovf_sticky", ovf1, 1);
    issue(16'h8100, 16'h8100, 16'h0400, OVF_NEG);
    repeat (20) @(negedge clk);

    // clear during MUL drops the pending write
    issue(16'h0100, 16'h0200, 16'h0080, 16'h0180);
    repeat (4) @(negedge clk);
    clear = 1'b1;
    q1.delete();
    exp_addr = 0;
    @(negedge clk); clear = 1'b0;
    #1;
    chk("clear_busy", busy1, 0);
    chk("clear_ovf", ovf1, 0);
    chk("clear_mul_addr", bus1.mem_addr, 0);
    @(negedge clk); clear = 1'b1; bus1.ch_valid = 2'b11;
    #1;
    chk("clear_ready", bus1.ch_ready, 0);
    @(negedge clk); clear = 1'b0; bus1.ch_valid = 2'b00;
    #1;
    chk("clear_no_accept", busy1, 0);
    repeat (25) @(negedge clk);

    // asynchronous reset during MUL
    issue(16'h0100, 16'h0200, 16'h0080, 16'h0180);
    repeat (20) @(negedge clk);
    chk("pre_rst_wdata", bus1.mem_wdata, 16'h0180);
    issue(16'h7F00, 16'h7F00, 16'h0400, OVF_POS);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    q1.delete();
    exp_addr = 0;
    chk("arst_busy", busy1, 0);
    chk("arst_addr", bus1.mem_addr, 0);
    chk("arst_wdata", bus1.mem_wdata, 0);
    chk("arst_we", bus1.mem_we, 0);
    chk("arst_ovf", ovf1, 0);
    @(negedge clk); rst = 1'b1;
    issue(16'h0300, 16'hFE00, 16'hFF00, 16'hFF00);
    repeat (25) @(negedge clk);

    for (int i = 0; i < 2000 && !done2; i++) @(negedge clk);
    chk("wrap_done", done2, 1);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/euler_join_unit.md
# euler_join_unit

- N-channel successor to the two-pipe join stage in the Euler module.
- Waits until every upstream pipe has a derivative term ready, then sums the terms and scales the sum by the step size `h_step` with an iterative signed fixed-point multiplier.
- Writes each result to the state RAM at an auto-incrementing address.
- Sits between the per-term derivative pipes and the state memory; the Euler controller observes it through `finished` and `busy`.

## Interface
Parameters:
- NUM_CH, 2, number of joined channels (≥2)
- DATA_SIZE, 16, signed two's-complement word width
- FRAC_BITS, 8, fractional bits of the fixed-point format
- ADD_SIZE, 16, RAM address width
- BASE_ADDR, 0, first write address after reset/clear

Ports (clock and reset first):
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort/restart; takes priority over all other inputs.
- ch_valid  in  NUM_CH  per-channel data valid.
- ch_data  in  NUM_CH*DATA_SIZE  channel i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- ch_ready  out  NUM_CH  per-channel accept strobe.
- h_step  in  DATA_SIZE  step size, sampled at accept.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADD_SIZE  RAM write address.
- mem_wdata  out  DATA_SIZE  RAM write data.
- busy  out  1  high outside IDLE.
- finished  out  1  one-cycle pulse, coincident with mem_we.
- overflow_flag  out  1  sticky overflow indicator.

## Operation
State machine with states IDLE, MUL, WRITE.

IDLE:
- `accept = all(ch_valid) & ~clear`.
- `ch_ready[i] = accept` for every i (combinational, all-or-nothing). No channel is consumed alone.
- On the accept edge:
  - sum all channels sign-extended to S = DATA_SIZE + clog2(NUM_CH) bits; the sum cannot overflow.
  - capture `h_step`.
  - load the multiplier.
  - go to MUL.

MUL:
- Radix-2 shift-add on magnitudes; sign applied at the end.
- Exactly DATA_SIZE cycles, then go to WRITE.
- Product width is S+DATA_SIZE.
- Result = product >>> FRAC_BITS, arithmetic shift with truncation toward −inf.

WRITE:
- Assert `mem_we` and `finished` for one cycle.
- `mem_addr` = current address counter; `mem_wdata` = result.
- At the end of WRITE the counter increments; return to IDLE.

Address counter:
- Wraps modulo 2^ADD_SIZE with no flag.

Overflow:
- A result that does not fit in DATA_SIZE signed bits sets `overflow_flag`.
- The flag holds until `rst` or `clear`.
- The written value depends on JOIN_SATURATE_EN (see Configuration).

Abort behaviour:
- `clear` in any state: return to IDLE, address := BASE_ADDR, overflow_flag := 0, no write that cycle, `ch_ready` low.
- `rst` asserted mid-operation: same as `clear`, but asynchronous. The pending result is discarded.

## Timing
- Reset values:
  - state IDLE
  - mem_addr = BASE_ADDR
  - mem_we, finished, busy, overflow_flag = 0
  - mem_wdata = 0
  - ch_ready = 0 (no valids)
- Latency: accept at edge T → `mem_we` high during cycle T+DATA_SIZE+1. The next accept is possible at the end of that WRITE cycle's successor IDLE cycle.
- Throughput: one result per DATA_SIZE+2 cycles.
- `busy` is high from the cycle after the accept through WRITE inclusive.
- `h_step` and `ch_data` may change freely after the accept edge.
- Valids held high through completion are not re-consumed while busy. They are accepted again in the next IDLE cycle.
- `mem_wdata` and `mem_addr` hold their last values outside WRITE.

## Configuration
JOIN_SATURATE_EN:
- Defined: an overflowing result is clamped to 2^(DATA_SIZE−1)−1 or −2^(DATA_SIZE−1) according to sign.
- Undefined: the low DATA_SIZE bits are written (wrap).
- `overflow_flag` behaves identically in both builds.

## Test plan
- Defaults, rst released:
  - ch_data = {0x0100, 0x0200} (1.0, 2.0), h_step = 0x0080 (0.5).
  - Both valids high for one cycle.
  - Expect ch_ready=2'b11 that cycle, mem_we 17 cycles later, addr 0, wdata 0x0180, finished pulse.
- Back-to-back: valids held high for 3 results.
  - Expect writes to addresses 0, 1, 2 spaced 18 cycles apart.
  - Expect no acceptance while busy.
- Partial valid: only ch_valid[0] high for 50 cycles.
  - Expect ch_ready=0, busy=0, no write.
  - Raising ch_valid[1] triggers a normal accept.
- Overflow: {0x7F00, 0x7F00}, h_step=0x0400 (4.0).
  - Expect overflow_flag=1 sticky.
  - Expect wdata 0x7FFF with JOIN_SATURATE_EN, truncated low bits without it.
  - Negative operands saturate to 0x8000.
- Abort and wrap:
  - clear asserted in MUL: no write, addr back to 0, flag cleared.
  - rst pulled low mid-MUL: outputs reset immediately.
  - ADD_SIZE=2, five results: addresses 0, 1, 2, 3, 0.
